// File: rtl/seg_pattern_sequencer.sv
// Step scheduler for the segment fade engine: walks an 8-entry (segment, level)
// table at a selectable rate and issues one light command per step over valid/ready.
//
//   state   | meaning
//   IDLE    | stopped, no command pending
//   ISSUE   | latch table[step_idx] (first cycle), then hold cmd_valid until accepted
//   WAIT    | step-period timer running before the next advance
module seg_pattern_sequencer #(
  parameter int STEP_WIDTH  = 24,
  parameter int NUM_STEPS   = 8,
  parameter int LEVEL_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic                   direction,
  input  logic [2:0]             speed,
  input  logic [2:0]             cfg_len,
  input  logic                   cfg_wr,
  input  logic [2:0]             cfg_addr,
  input  logic [7:0]             cfg_data,
  input  logic                   cmd_ready,
  output logic                   cmd_valid,
  output logic [2:0]             cmd_seg,
  output logic [LEVEL_WIDTH-1:0] cmd_level,
  output logic [2:0]             step_idx,
  output logic                   busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [7:0]             table_q [NUM_STEPS];
  logic [7:0]             table_d [NUM_STEPS];
  logic [STEP_WIDTH-1:0]  counter_q, counter_d;
  logic [2:0]             step_idx_q, step_idx_d;
  logic                   cmd_valid_q, cmd_valid_d;
  logic [2:0]             cmd_seg_q, cmd_seg_d;
  logic [LEVEL_WIDTH-1:0] cmd_level_q, cmd_level_d;

  logic [STEP_WIDTH-1:0]  period;
  logic [2:0]             next_idx;

  // Slowest rate sets the top counter bits; the low bits are always all ones.
  assign period = {speed ^ 3'b111, {(STEP_WIDTH-3){1'b1}}};

  always_comb begin
    next_idx = step_idx_q;
    if (direction) begin
      if (step_idx_q >= cfg_len) next_idx = 3'd0;
      else                       next_idx = step_idx_q + 3'd1;
    end else begin
      if (step_idx_q == 3'd0 || step_idx_q > cfg_len) next_idx = cfg_len;
      else                                            next_idx = step_idx_q - 3'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    counter_d   = counter_q;
    step_idx_d  = step_idx_q;
    cmd_valid_d = cmd_valid_q;
    cmd_seg_d   = cmd_seg_q;
    cmd_level_d = cmd_level_q;
    for (int i = 0; i < NUM_STEPS; i++) table_d[i] = table_q[i];
    if (cfg_wr) table_d[cfg_addr] = cfg_data;

    case (state_q)
      S_IDLE: begin
        cmd_valid_d = 1'b0;
        if (run) begin
          state_d    = S_ISSUE;
          step_idx_d = direction ? 3'd0 : cfg_len;
        end
      end
      S_ISSUE: begin
        if (!cmd_valid_q) begin
          // Payload is a private copy so table rewrites cannot disturb a pending command.
          cmd_seg_d   = table_q[step_idx_q][7:5];
          cmd_level_d = table_q[step_idx_q][LEVEL_WIDTH-1:0];
          cmd_valid_d = 1'b1;
        end else if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          counter_d   = '0;
          state_d     = run ? S_WAIT : S_IDLE;
        end
      end
      S_WAIT: begin
        if (!run) begin
          state_d   = S_IDLE;
          counter_d = '0;
        end else if (counter_q >= period) begin
          step_idx_d = next_idx;
          state_d    = S_ISSUE;
        end else begin
          counter_d = counter_q + {{(STEP_WIDTH-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d     = S_IDLE;
        cmd_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      counter_q   <= '0;
      step_idx_q  <= 3'd0;
      cmd_valid_q <= 1'b0;
      cmd_seg_q   <= 3'd0;
      cmd_level_q <= '0;
      for (int i = 0; i < NUM_STEPS; i++) table_q[i] <= 8'd0;
    end else begin
      state_q     <= state_d;
      counter_q   <= counter_d;
      step_idx_q  <= step_idx_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_seg_q   <= cmd_seg_d;
      cmd_level_q <= cmd_level_d;
      for (int i = 0; i < NUM_STEPS; i++) table_q[i] <= table_d[i];
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_seg   = cmd_seg_q;
  assign cmd_level = cmd_level_q;
  assign step_idx  = step_idx_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_seg_pattern_sequencer.sv
// Bench for seg_pattern_sequencer: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a behavioural model.
module tb_seg_pattern_sequencer;
  localparam int W = 6;

  logic       clk = 1'b0;
  logic       reset, run, direction, cfg_wr, cmd_ready;
  logic [2:0] speed, cfg_len, cfg_addr;
  logic [7:0] cfg_data;
  logic       cmd_valid, busy;
  logic [2:0] cmd_seg, step_idx;
  logic [4:0] cmd_level;

  int vectors = 0;
  int miscompares = 0;
  bit chk_on = 1'b0;

  seg_pattern_sequencer #(.STEP_WIDTH(W), .NUM_STEPS(8), .LEVEL_WIDTH(5)) dut (
    .clk(clk), .reset(reset), .run(run), .direction(direction), .speed(speed),
    .cfg_len(cfg_len), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cmd_ready(cmd_ready), .cmd_valid(cmd_valid), .cmd_seg(cmd_seg),
    .cmd_level(cmd_level), .step_idx(step_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural model: phase 0 stopped, 1 fetching entry, 2 offering command, 3 timing a period.
  bit [7:0] m_tab [8];
  int m_phase = 0, m_elapsed = 0, m_idx = 0, m_seg = 0, m_lvl = 0;
  bit m_valid = 1'b0;

  function automatic int period_of(int s);
    return ((7 - s) << (W - 3)) + ((1 << (W - 3)) - 1);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) m_tab[i] = 8'd0;
      m_phase = 0; m_elapsed = 0; m_idx = 0; m_seg = 0; m_lvl = 0; m_valid = 1'b0;
    end else begin
      case (m_phase)
        0: if (run) begin m_phase = 1; m_idx = direction ? 0 : int'(cfg_len); end
        1: begin
          m_seg = m_tab[m_idx] / 32; m_lvl = m_tab[m_idx] % 32;
          m_valid = 1'b1; m_phase = 2;
        end
        2: if (cmd_ready) begin m_valid = 1'b0; m_elapsed = 0; m_phase = run ? 3 : 0; end
        default: begin
          if (!run) begin m_phase = 0; m_elapsed = 0; end
          else if (m_elapsed >= period_of(int'(speed))) begin
            if (direction) m_idx = (m_idx >= int'(cfg_len)) ? 0 : m_idx + 1;
            else m_idx = (m_idx == 0 || m_idx > int'(cfg_len)) ? int'(cfg_len) : m_idx - 1;
            m_phase = 1;
          end else m_elapsed++;
        end
      endcase
      if (cfg_wr) m_tab[cfg_addr] = cfg_data;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wr(input int a, input int d);
    cfg_wr = 1'b1; cfg_addr = 3'(a); cfg_data = 8'(d);
    tick();
    cfg_wr = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    bit ok = 1'b0;
    n = 0;
    for (int k = 0; k < 300; k++) begin
      tick(); n++;
      if (cmd_valid) begin ok = 1'b1; break; end
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL wait_valid: cmd_valid not seen within 300 cycles at %0t", $time);
    end
  endtask

  initial begin
    int n;
    int exp_up[4] = '{1, 2, 6, 4};
    int exp_dn_seg[5] = '{4, 6, 2, 1, 4};
    int exp_dn_idx[5] = '{3, 2, 1, 0, 3};

    reset = 1'b1; run = 1'b0; direction = 1'b1; speed = 3'd7; cfg_len = 3'd0;
    cfg_wr = 1'b0; cfg_addr = 3'd0; cfg_data = 8'd0; cmd_ready = 1'b1;

    fork
      forever begin
        @(negedge clk);
        if (chk_on) begin
          vectors++;
          if ({cmd_valid, cmd_seg, cmd_level, step_idx, busy} !==
              {m_valid, 3'(m_seg), 5'(m_lvl), 3'(m_idx), (m_phase != 0)}) begin
            miscompares++;
            $display("FAIL cycle_compare t=%0t got v=%0b seg=%0d lvl=%0d idx=%0d busy=%0b expected v=%0b seg=%0d lvl=%0d idx=%0d busy=%0b",
                     $time, cmd_valid, cmd_seg, cmd_level, step_idx, busy,
                     m_valid, m_seg, m_lvl, m_idx, (m_phase != 0));
          end
        end
      end
    join_none

    tick(); tick();
    reset = 1'b0;
    chk_on = 1'b1;
    check("reset_valid", int'(cmd_valid), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_idx", int'(step_idx), 0);

    // Ascending walk of a 4-entry table at period 7.
    wr(0, 8'h3F); wr(1, 8'h5F); wr(2, 8'hDF); wr(3, 8'h9F);
    cfg_len = 3'd3; direction = 1'b1; run = 1'b1;
    wait_valid(n);
    check("start_latency", n, 2);
    check("up_seg0", int'(cmd_seg), 1);
    check("up_lvl0", int'(cmd_level), 31);
    for (int i = 1; i <= 4; i++) begin
      wait_valid(n);
      check("up_gap", n, 10);
      check("up_seg", int'(cmd_seg), exp_up[i % 4]);
    end

    // Descending walk.
    run = 1'b0;
    repeat (12) tick();
    direction = 1'b0; run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_valid(n);
      check("dn_seg", int'(cmd_seg), exp_dn_seg[i]);
      check("dn_idx", int'(step_idx), exp_dn_idx[i]);
    end

    // Back-pressure: payload must survive a rewrite of its entry and a run drop.
    cmd_ready = 1'b0;
    wr(3, 8'h00);
    repeat (20) tick();
    check("hold_valid", int'(cmd_valid), 1);
    check("hold_seg", int'(cmd_seg), 4);
    check("hold_lvl", int'(cmd_level), 31);
    run = 1'b0;
    repeat (3) tick();
    check("hold_after_stop_valid", int'(cmd_valid), 1);
    check("hold_after_stop_busy", int'(busy), 1);
    cmd_ready = 1'b1;
    tick();
    check("release_valid", int'(cmd_valid), 0);
    check("release_busy", int'(busy), 0);

    // Reset while a command is stalled.
    direction = 1'b1; run = 1'b1;
    wait_valid(n);
    cmd_ready = 1'b0;
    reset = 1'b1;
    tick();
    check("rst_mid_valid", int'(cmd_valid), 0);
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_idx", int'(step_idx), 0);
    reset = 1'b0; cmd_ready = 1'b1;
    wait_valid(n);
    check("rst_table_seg", int'(cmd_seg), 0);
    check("rst_table_lvl", int'(cmd_level), 0);
    run = 1'b0;
    repeat (4) tick();

    // Slowest rate, then length shrink while past the new end.
    for (int i = 0; i < 8; i++) wr(i, (i << 5) | (i + 3));
    cfg_len = 3'd7; direction = 1'b1; speed = 3'd0; run = 1'b1;
    wait_valid(n);
    wait_valid(n);
    check("slow_gap", n, 66);
    check("slow_idx", int'(step_idx), 1);
    speed = 3'd7;
    for (int k = 0; k < 10 && step_idx != 3'd5; k++) wait_valid(n);
    check("reach_idx5", int'(step_idx), 5);
    cfg_len = 3'd2;
    wait_valid(n);
    check("shrink_wrap_idx", int'(step_idx), 0);
    check("shrink_wrap_seg", int'(cmd_seg), 0);

    // Single-step sequence.
    run = 1'b0;
    repeat (3) tick();
    cfg_len = 3'd0; run = 1'b1;
    wait_valid(n);
    for (int i = 0; i < 3; i++) begin
      wait_valid(n);
      check("len0_gap", n, 10);
      check("len0_idx", int'(step_idx), 0);
      check("len0_lvl", int'(cmd_level), 3);
    end

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      reset     = ($urandom % 200) == 0;
      run       = ($urandom % 20) != 0;
      cmd_ready = ($urandom % 3) != 0;
      if ($urandom % 40 == 0) direction = ~direction;
      if ($urandom % 60 == 0) speed = 3'(4 + $urandom % 4);
      if ($urandom % 80 == 0) cfg_len = 3'($urandom % 8);
      cfg_wr   = ($urandom % 5) == 0;
      cfg_addr = 3'($urandom % 8);
      cfg_data = 8'($urandom % 256);
      tick();
    end
    cfg_wr = 1'b0; reset = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
